vga_scan_timer: RTL and testbench

- Generates 640x480@60 Hz VGA raster timing from the 50 MHz `sysclk`.
- Presents the current pixel address to the display-colour path (container switcher / function GPUs) and registers the 3-bit colour returned.
- Drives `VGA_R/G/B/HS/VS` with colour and sync aligned.
- Sits directly downstream of the container switcher and is the last stage before the pins.

---
 rtl/vga_timing_pkg.sv | 42 ++++
 rtl/pixel_tick_gen.sv | 30 +++
 rtl/vga_scan_timer.sv | 119 +++++++++++
 tb/tb_vga_scan_timer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster definitions: timing constants, colour type and the
// {y,x} pixel address layout used by the GPUs, the container switcher and the scan timer.
package vga_timing_pkg;

  localparam int VGA_CLK_DIV  = 2;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int CNT_W  = 11;
  localparam int ADDR_W = 2 * CNT_W;

  typedef logic [2:0] rgb_t;

  typedef struct packed {
    logic [CNT_W-1:0] y;
    logic [CNT_W-1:0] x;
  } pix_addr_t;

  function automatic pix_addr_t make_addr(input logic [CNT_W-1:0] y,
                                          input logic [CNT_W-1:0] x);
    pix_addr_t a;
    a.y = y;
    a.x = x;
    return a;
  endfunction

  function automatic logic in_window(input logic [CNT_W-1:0] c,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-clock enable: divides sysclk by CLK_DIV and raises tick_o on the last
// sysclk cycle of every pixel period.
module pixel_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  always_comb begin
    tick_o = (div_q == DIV_MAX);
    div_d  = tick_o ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/vga_scan_timer.sv
// VGA raster timer: walks the {y,x} raster, presents the address to the colour
// path and registers colour plus negative-polarity sync one pixel later.
module vga_scan_timer
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = VGA_CLK_DIV,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic [2:0]  pixel_data,
  output logic [21:0] pixel_addr,
  output logic        pixel_valid,
  output logic        frame_start,
  output logic        VGA_R,
  output logic        VGA_G,
  output logic        VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_size_check
    $error("vga_scan_timer: H_TOTAL/V_TOTAL exceed the 11-bit raster counters");
  end

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_LO  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_HI  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_LO  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_HI  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic             tick;
  logic             line_end;
  logic             frame_end;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             valid_q, valid_d;
  logic             fs_q, fs_d;
  rgb_t             rgb_q, rgb_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_i  (sysclk),
    .rst_ni (rst),
    .tick_o (tick)
  );

  always_comb begin
    h_d       = h_q;
    v_d       = v_q;
    fs_d      = 1'b0;
    rgb_d     = rgb_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    line_end  = (h_q == H_LAST);
    frame_end = line_end && (v_q == V_LAST);

    if (tick) begin
      h_d = line_end ? '0 : h_q + 1'b1;
      if (line_end) begin
        v_d = frame_end ? '0 : v_q + 1'b1;
      end
      fs_d  = frame_end;
      // Output stage samples the address currently on the bus, so pins lag it by one pixel.
      rgb_d = valid_q ? rgb_t'(pixel_data) : '0;
      hs_d  = ~in_window(h_q, HS_LO, HS_HI);
      vs_d  = ~in_window(v_q, VS_LO, VS_HI);
    end

    // Registered from the next counter value so pixel_valid always matches pixel_addr.
    valid_d = (h_d < H_ACT) && (v_d < V_ACT);
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      h_q     <= '0;
      v_q     <= '0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      rgb_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
      rgb_q   <= rgb_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
    end
  end

  assign pixel_addr  = make_addr(v_q, h_q);
  assign pixel_valid = valid_q;
  assign frame_start = fs_q;
  assign VGA_R       = rgb_q[2];
  assign VGA_G       = rgb_q[1];
  assign VGA_B       = rgb_q[0];
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;

endmodule

// File: tb/tb_vga_scan_timer.sv
// Directed bench for vga_scan_timer: full 800-pixel lines, vertical timing
// shortened to 8 lines per frame (4 active, FP 1, sync 2, BP 1).
module tb_vga_scan_timer;

  localparam int LINE_CYC  = 1600;
  localparam int FRAME_CYC = 8 * LINE_CYC;
  localparam int BOUND     = 14000;

  logic        sysclk = 1'b0;
  logic        rst;
  logic [2:0]  pixel_data;
  logic [21:0] pixel_addr;
  logic        pixel_valid;
  logic        frame_start;
  logic        VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS;
  logic        mode;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [10:0] max_x = '0;
  logic [10:0] max_y = '0;

  vga_scan_timer #(
    .CLK_DIV  (2),
    .H_ACTIVE (640),
    .H_FP     (16),
    .H_SYNC   (96),
    .H_BP     (48),
    .V_ACTIVE (4),
    .V_FP     (1),
    .V_SYNC   (2),
    .V_BP     (1)
  ) dut (
    .sysclk      (sysclk),
    .rst         (rst),
    .pixel_data  (pixel_data),
    .pixel_addr  (pixel_addr),
    .pixel_valid (pixel_valid),
    .frame_start (frame_start),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS)
  );

  always #10 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  // Upstream colour source: either x[2:0] of the address or constant white.
  always_comb pixel_data = mode ? 3'b111 : pixel_addr[2:0];

  always @(negedge sysclk) begin
    if (rst === 1'b1) begin
      if (pixel_addr[10:0] > max_x) max_x <= pixel_addr[10:0];
      if (pixel_addr[21:11] > max_y) max_y <= pixel_addr[21:11];
    end
  end

  function automatic logic [21:0] xy(input int y, input int x);
    return {11'(y), 11'(x)};
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0:       return VGA_HS;
      1:       return VGA_VS;
      default: return frame_start;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_addr(input string tag, input logic [21:0] a);
    int n = 0;
    while (pixel_addr !== a && n < BOUND) begin
      @(negedge sysclk);
      n++;
    end
    check({tag, "_reach"}, 32'(pixel_addr === a), 32'd1);
  endtask

  task automatic wait_change(input string tag);
    logic [21:0] a;
    int n = 0;
    a = pixel_addr;
    do begin
      @(negedge sysclk);
      n++;
    end while (pixel_addr === a && n < BOUND);
    check({tag, "_change"}, 32'(pixel_addr !== a), 32'd1);
  endtask

  task automatic wait_edge(input string tag, input int sel, input logic lvl, output int t);
    logic prev, cur;
    int n = 0;
    bit hit = 1'b0;
    cur = sig(sel);
    while (!hit && n < BOUND) begin
      prev = cur;
      @(negedge sysclk);
      n++;
      cur = sig(sel);
      hit = (prev !== lvl) && (cur === lvl);
    end
    t = cyc;
    check({tag, "_edge"}, 32'(hit), 32'd1);
  endtask

  initial begin
    int c0, t1, t2, t3;
    rst  = 1'b0;
    mode = 1'b0;

    // Reset held low
    repeat (10) @(negedge sysclk);
    check("rst_hs",    32'(VGA_HS), 32'd1);
    check("rst_vs",    32'(VGA_VS), 32'd1);
    check("rst_rgb",   32'({VGA_R, VGA_G, VGA_B}), 32'd0);
    check("rst_addr",  32'(pixel_addr), 32'd0);
    check("rst_valid", 32'(pixel_valid), 32'd0);
    check("rst_fs",    32'(frame_start), 32'd0);

    // Release: valid on first edge, first tick on second edge, no frame_start
    rst = 1'b1;
    c0  = cyc;
    @(negedge sysclk);
    check("rel_valid", 32'(pixel_valid), 32'd1);
    check("rel_addr",  32'(pixel_addr), 32'd0);
    check("rel_fs",    32'(frame_start), 32'd0);
    @(negedge sysclk);
    check("first_tick_addr", 32'(pixel_addr), 32'(xy(0, 1)));
    check("first_tick_fs",   32'(frame_start), 32'd0);

    // Colour path: pins carry the previous pixel's x[2:0]
    wait_addr("x100", xy(0, 100));
    wait_change("x100");
    check("col_addr", 32'(pixel_addr), 32'(xy(0, 101)));
    check("col_rgb",  32'({VGA_R, VGA_G, VGA_B}), 32'd4);
    wait_addr("x639", xy(0, 639));
    check("x639_valid", 32'(pixel_valid), 32'd1);
    check("x639_rgb",   32'({VGA_R, VGA_G, VGA_B}), 32'd6);
    wait_change("x639");
    check("x640_addr",  32'(pixel_addr), 32'(xy(0, 640)));
    check("x640_valid", 32'(pixel_valid), 32'd0);
    check("x640_rgb",   32'({VGA_R, VGA_G, VGA_B}), 32'd7);

    // Blanking forces black even with white input
    mode = 1'b1;
    wait_addr("x700", xy(0, 700));
    check("blank_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
    wait_addr("x799", xy(0, 799));
    wait_change("x799");
    check("line_wrap_addr", 32'(pixel_addr), 32'(xy(1, 0)));
    check("line_wrap_rgb",  32'({VGA_R, VGA_G, VGA_B}), 32'd0);
    wait_change("l1x0");
    check("white_addr", 32'(pixel_addr), 32'(xy(1, 1)));
    check("white_rgb",  32'({VGA_R, VGA_G, VGA_B}), 32'd7);
    mode = 1'b0;

    // Horizontal sync timing
    wait_edge("hs_fall1", 0, 1'b0, t1);
    wait_edge("hs_rise",  0, 1'b1, t2);
    wait_edge("hs_fall2", 0, 1'b0, t3);
    check("hs_low",    32'(t2 - t1), 32'd192);
    check("hs_period", 32'(t3 - t1), 32'(LINE_CYC));

    // Vertical sync timing
    wait_edge("vs_fall1", 1, 1'b0, t1);
    wait_edge("vs_rise",  1, 1'b1, t2);
    wait_edge("vs_fall2", 1, 1'b0, t3);
    check("vs_low",    32'(t2 - t1), 32'd3200);
    check("vs_period", 32'(t3 - t1), 32'(FRAME_CYC));

    // Wrap corner and frame_start
    wait_addr("corner", xy(7, 799));
    check("corner_fs", 32'(frame_start), 32'd0);
    wait_change("corner");
    check("wrap_addr", 32'(pixel_addr), 32'd0);
    check("wrap_fs",   32'(frame_start), 32'd1);
    t1 = cyc;
    @(negedge sysclk);
    check("fs_width", 32'(frame_start), 32'd0);
    wait_edge("fs_next", 2, 1'b1, t2);
    check("fs_period", 32'(t2 - t1), 32'(FRAME_CYC));
    check("fs_addr",   32'(pixel_addr), 32'd0);

    // Asynchronous reset mid-frame
    wait_addr("mid", xy(2, 300));
    check("mid_rgb_live", 32'({VGA_R, VGA_G, VGA_B}), 32'd3);
    #2 rst = 1'b0;
    #1;
    check("async_addr",  32'(pixel_addr), 32'd0);
    check("async_valid", 32'(pixel_valid), 32'd0);
    check("async_rgb",   32'({VGA_R, VGA_G, VGA_B}), 32'd0);
    check("async_hs",    32'(VGA_HS), 32'd1);
    check("async_vs",    32'(VGA_VS), 32'd1);
    check("async_fs",    32'(frame_start), 32'd0);
    repeat (3) @(negedge sysclk);
    rst = 1'b1;
    c0  = cyc;
    @(negedge sysclk);
    check("rel2_addr",  32'(pixel_addr), 32'd0);
    check("rel2_valid", 32'(pixel_valid), 32'd1);
    check("rel2_fs",    32'(frame_start), 32'd0);
    wait_edge("rel2_fs", 2, 1'b1, t1);
    check("rel2_fs_delay", 32'(t1 - c0), 32'(FRAME_CYC));

    check("max_x", 32'(max_x), 32'd799);
    check("max_y", 32'(max_y), 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
